// File: rtl/regs_file_if.sv
// Register-file bus: writeback write requests, decode read addresses and the
// combinational read data returned to decode.
interface regs_file_if #(
   parameter int READ_PORT  = 2,
   parameter int WRITE_PORT = 1
);
   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] uint32_t;

   typedef struct packed {
      logic      we;
      reg_addr_t waddr;
      uint32_t   wrdata;
   } regs_wreq_t;

   regs_wreq_t regs_wreq   [WRITE_PORT];
   reg_addr_t  regs_raddr  [READ_PORT];
   uint32_t    regs_rddata [READ_PORT];

   // No handshake: a request with we=1 is consumed at the edge it is presented,
   // and read data follows regs_raddr in the same cycle.
   modport master (output regs_wreq, output regs_raddr, input regs_rddata);
   modport slave  (input regs_wreq, input regs_raddr, output regs_rddata);
endinterface

// File: rtl/regs_file.sv
// 32x32 register file with a post-reset clear sequence (INIT) before RUN.
// Optional same-cycle write-to-read bypass is enabled by REGS_FILE_BYPASS_EN.
module regs_file #(
   parameter int READ_PORT  = 2,
   parameter int WRITE_PORT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   regs_file_if.slave  regs_bus,
   output logic        ready,
   output logic        dbg_state_o,
   output logic [4:0]  dbg_idx_o
);

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        ready_q, ready_d;
   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      regs_d  = regs_q;
      case (state_q)
         INIT: begin
            regs_d[idx_q] = '0;
            idx_d         = idx_q + 5'd1;
            if (idx_q == 5'd31) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Ascending port order lets the highest-indexed port win a collision.
            for (int w = 0; w < WRITE_PORT; w++) begin
               if (regs_bus.regs_wreq[w].we && (regs_bus.regs_wreq[w].waddr != 5'd0)) begin
                  regs_d[regs_bus.regs_wreq[w].waddr] = regs_bus.regs_wreq[w].wrdata;
               end
            end
         end
      endcase
      regs_d[0] = '0;
      ready_d   = (state_d == RUN);
   end

   // Storage is left untouched during reset so in-flight writes are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= INIT;
         idx_q   <= 5'd1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
         regs_q  <= regs_d;
      end
   end

   always_comb begin
      for (int p = 0; p < READ_PORT; p++) begin
         regs_bus.regs_rddata[p] = '0;
         if ((state_q == RUN) && (regs_bus.regs_raddr[p] != 5'd0)) begin
            regs_bus.regs_rddata[p] = regs_q[regs_bus.regs_raddr[p]];
`ifdef REGS_FILE_BYPASS_EN
            for (int w = 0; w < WRITE_PORT; w++) begin
               if (regs_bus.regs_wreq[w].we &&
                   (regs_bus.regs_wreq[w].waddr == regs_bus.regs_raddr[p])) begin
                  regs_bus.regs_rddata[p] = regs_bus.regs_wreq[w].wrdata;
               end
            end
`endif
         end
      end
   end

   assign ready       = ready_q;
   assign dbg_state_o = state_q;
   assign dbg_idx_o   = idx_q;

endmodule

// File: tb/tb_regs_file.sv
// Directed-plus-random bench for regs_file against an array-based reference model.
module tb_regs_file;
   localparam int RP = 2;
   localparam int WP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ready;
   logic       dbg_state;
   logic [4:0] dbg_idx;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] m_mem [32];
   bit          m_run = 1'b0;
   int          m_cnt = 0;

   always #5 clk = ~clk;

   regs_file_if #(.READ_PORT(RP), .WRITE_PORT(WP)) rif ();

   regs_file #(.READ_PORT(RP), .WRITE_PORT(WP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .regs_bus    (rif.slave),
      .ready       (ready),
      .dbg_state_o (dbg_state),
      .dbg_idx_o   (dbg_idx)
   );

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: no reads before the clear finishes; address 0 is always zero.
   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic [31:0] v;
      if (!m_run || a == 5'd0) return 32'd0;
      v = m_mem[a];
`ifdef REGS_FILE_BYPASS_EN
      for (int w = 0; w < WP; w++) begin
         if (rif.regs_wreq[w].we && rif.regs_wreq[w].waddr == a) v = rif.regs_wreq[w].wrdata;
      end
`endif
      return v;
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         m_run = 1'b0;
         m_cnt = 0;
      end else if (!m_run) begin
         m_cnt++;
         if (m_cnt == 31) begin
            m_run = 1'b1;
            for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
         end
      end else begin
         for (int w = 0; w < WP; w++) begin
            if (rif.regs_wreq[w].we && rif.regs_wreq[w].waddr != 5'd0)
               m_mem[rif.regs_wreq[w].waddr] = rif.regs_wreq[w].wrdata;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      #1;
      for (int p = 0; p < RP; p++) begin
         chk($sformatf("%s_rd%0d", tag, p), rif.regs_rddata[p], model_read(rif.regs_raddr[p]));
      end
      chk({tag, "_ready"}, {31'd0, ready}, {31'd0, m_run});
      chk({tag, "_state"}, {31'd0, dbg_state}, {31'd0, m_run});
      if (!m_run) chk({tag, "_idx"}, {27'd0, dbg_idx}, 32'((m_cnt + 1) % 32));
   endtask

   task automatic idle();
      for (int w = 0; w < WP; w++) begin
         rif.regs_wreq[w].we     = 1'b0;
         rif.regs_wreq[w].waddr  = 5'd0;
         rif.regs_wreq[w].wrdata = 32'd0;
      end
      for (int p = 0; p < RP; p++) rif.regs_raddr[p] = 5'd0;
   endtask

   task automatic set_write(input int w, input logic we, input logic [4:0] a, input logic [31:0] d);
      rif.regs_wreq[w].we     = we;
      rif.regs_wreq[w].waddr  = a;
      rif.regs_wreq[w].wrdata = d;
   endtask

   task automatic drive_random();
      for (int w = 0; w < WP; w++) begin
         set_write(w, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
                   $urandom);
      end
      for (int p = 0; p < RP; p++) begin
         rif.regs_raddr[p] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                         : 5'($urandom_range(0, 31));
      end
   endtask

   task automatic sweep_all(input string tag);
      idle();
      for (int a = 0; a < 16; a++) begin
         rif.regs_raddr[0] = 5'(2 * a);
         rif.regs_raddr[1] = 5'(2 * a + 1);
         check_all(tag);
         tick();
      end
   endtask

   task automatic run_init(input string tag);
      for (int i = 0; i < 31; i++) begin
         drive_random();
         check_all(tag);
         tick();
      end
      idle();
      check_all({tag, "_done"});
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      check_all("reset");

      rst_n = 1'b1;
      run_init("init");
      sweep_all("cleared");

      set_write(0, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      idle();
      rif.regs_raddr[1] = 5'd5;
      check_all("wr5");
      chk("wr5_abs", rif.regs_rddata[1], 32'hDEADBEEF);
      set_write(0, 1'b1, 5'd0, 32'h1234);
      tick();
      idle();
      check_all("wr0");
      chk("wr0_abs", rif.regs_rddata[0], 32'd0);

      set_write(0, 1'b1, 5'd7, 32'h11);
      set_write(1, 1'b1, 5'd7, 32'h22);
      tick();
      idle();
      rif.regs_raddr[0] = 5'd7;
      check_all("collide7");
      chk("collide7_abs", rif.regs_rddata[0], 32'h22);

      set_write(0, 1'b1, 5'd3, 32'h1);
      tick();
      idle();
      set_write(0, 1'b1, 5'd3, 32'hA5A5A5A5);
      rif.regs_raddr[0] = 5'd3;
      rif.regs_raddr[1] = 5'd3;
      check_all("bypass3");
`ifdef REGS_FILE_BYPASS_EN
      chk("bypass3_abs", rif.regs_rddata[0], 32'hA5A5A5A5);
`else
      chk("bypass3_abs", rif.regs_rddata[0], 32'h1);
`endif
      tick();
      idle();
      rif.regs_raddr[0] = 5'd3;
      rif.regs_raddr[1] = 5'd3;
      check_all("after3");
      chk("after3_abs", rif.regs_rddata[1], 32'hA5A5A5A5);

      for (int i = 0; i < 300; i++) begin
         drive_random();
         check_all("rand");
         tick();
      end

      idle();
      set_write(1, 1'b1, 5'd9, 32'h55);
      tick();
      idle();
      rif.regs_raddr[0] = 5'd9;
      check_all("wr9");
      set_write(0, 1'b1, 5'd9, 32'hFFFF0000);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run_init("reinit");
      rif.regs_raddr[0] = 5'd9;
      check_all("reg9_cleared");
      chk("reg9_abs", rif.regs_rddata[0], 32'd0);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         drive_random();
         check_all("partial");
         tick();
      end
      idle();
      check_all("idx15");
      chk("idx15_abs", {27'd0, dbg_idx}, 32'd15);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run_init("restart");
      sweep_all("final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
